// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns a debounced push-button level into one-cycle step
// pulses. A press held long enough is flagged as long and then auto-repeats.
// A running step count is kept for the debug display.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | button released, waiting for a fresh low->high transition
//   PRESSED | first step issued, counting toward the long-press threshold
//   HELD    | long press reached, issuing a repeat step every REPEAT_CYCLES
module step_pulse_gen #(
   parameter int unsigned LONG_PRESS_CYCLES = 25000000,
   parameter int unsigned REPEAT_CYCLES     = 5000000,
   parameter int unsigned CNT_W             = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_level,
   input  logic       en,
   output logic       step_pulse,
   output logic       long_press,
   output logic       held,
   output logic [7:0] step_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic             btn_prev;
   logic             rise;
   logic             issue_step;
   logic             issue_long;

   assign rise = btn_level & ~btn_prev;

   // State, hold counter, edge-detect history and registered outputs.
   // btn_prev resets to 1 so a button held through reset must be released
   // and pressed again before it can produce a step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         btn_prev   <= 1'b1;
         step_pulse <= 1'b0;
         long_press <= 1'b0;
         held       <= 1'b0;
         step_count <= 8'd0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_cnt_nxt;
         btn_prev   <= btn_level;
         step_pulse <= issue_step & en;
         long_press <= issue_long & en;
         held       <= (state_nxt == HELD);
         if (issue_step && en) begin
            step_count <= step_count + 8'd1;
         end
      end
   end

   // Next-state and pulse-issue decode; release is checked before the
   // threshold so a release on the threshold edge issues nothing.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      issue_step   = 1'b0;
      issue_long   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               issue_step   = 1'b1;
               state_nxt    = PRESSED;
               hold_cnt_nxt = '0;
            end
         end
         PRESSED: begin
            if (!btn_level) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == LONG_LAST) begin
               issue_step   = 1'b1;
               issue_long   = 1'b1;
               state_nxt    = HELD;
               hold_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!btn_level) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == REPEAT_LAST) begin
               issue_step   = 1'b1;
               hold_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with LONG_PRESS_CYCLES=8, REPEAT_CYCLES=3.
module tb_step_pulse_gen;

   logic       clk;
   logic       rst_n;
   logic       btn_level;
   logic       en;
   logic       step_pulse;
   logic       long_press;
   logic       held;
   logic [7:0] step_count;

   int total;
   int bad;
   int sp_seen;
   int lp_seen;
   int held_seen;
   logic exp_sp;

   step_pulse_gen #(
      .LONG_PRESS_CYCLES(8),
      .REPEAT_CYCLES    (3),
      .CNT_W            (25)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_level (btn_level),
      .en        (en),
      .step_pulse(step_pulse),
      .long_press(long_press),
      .held      (held),
      .step_count(step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are then sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      btn_level = 1'b0;
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      total = 0;
      bad = 0;
      en = 1'b1;
      btn_level = 1'b1;
      rst_n = 1'b0;
      #12;
      chk("reset_step_count", step_count, 8'd0);
      chk("reset_held", {7'd0, held}, 8'd0);

      // button held through reset: no pulse until a fresh press
      rst_n = 1'b1;
      sp_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (step_pulse) sp_seen++;
      end
      chk("held_thru_reset_pulses", 8'(sp_seen), 8'd0);
      chk("held_thru_reset_count", step_count, 8'd0);
      btn_level = 1'b0;
      tick();
      btn_level = 1'b1;
      tick();
      chk("repress_pulse", {7'd0, step_pulse}, 8'd1);
      chk("repress_count", step_count, 8'd1);
      btn_level = 1'b0;
      tick();
      chk("repress_single", {7'd0, step_pulse}, 8'd0);

      // short press of 5 cycles
      do_reset();
      btn_level = 1'b1;
      tick();
      chk("short_pulse", {7'd0, step_pulse}, 8'd1);
      sp_seen = 0; lp_seen = 0; held_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (step_pulse) sp_seen++;
         if (long_press) lp_seen++;
         if (held) held_seen++;
      end
      btn_level = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (step_pulse) sp_seen++;
         if (long_press) lp_seen++;
         if (held) held_seen++;
      end
      chk("short_extra_pulses", 8'(sp_seen), 8'd0);
      chk("short_long_press", 8'(lp_seen), 8'd0);
      chk("short_held", 8'(held_seen), 8'd0);
      chk("short_count", step_count, 8'd1);

      // 17-cycle hold after first pulse: pulses at 0,8,11,14,17
      do_reset();
      btn_level = 1'b1;
      for (int j = 0; j <= 17; j++) begin
         tick();
         exp_sp = (j == 0) || (j >= 8 && ((j - 8) % 3) == 0);
         chk($sformatf("hold_sp_%0d", j), {7'd0, step_pulse}, {7'd0, exp_sp});
         chk($sformatf("hold_lp_%0d", j), {7'd0, long_press}, {7'd0, (j == 8)});
         chk($sformatf("hold_held_%0d", j), {7'd0, held}, {7'd0, (j >= 8)});
      end
      btn_level = 1'b0;
      tick();
      chk("hold_release_held", {7'd0, held}, 8'd0);
      chk("hold_release_sp", {7'd0, step_pulse}, 8'd0);
      chk("hold_count", step_count, 8'd5);

      // release on the threshold edge: release wins
      do_reset();
      btn_level = 1'b1;
      tick();
      for (int j = 1; j <= 7; j++) tick();
      btn_level = 1'b0;
      tick();
      chk("race_sp", {7'd0, step_pulse}, 8'd0);
      chk("race_lp", {7'd0, long_press}, 8'd0);
      chk("race_held", {7'd0, held}, 8'd0);
      chk("race_count", step_count, 8'd1);
      tick();
      btn_level = 1'b1;
      tick();
      chk("race_idle_repress", {7'd0, step_pulse}, 8'd1);
      chk("race_count2", step_count, 8'd2);
      btn_level = 1'b0;
      tick();

      // en=0 for a 20-cycle hold
      en = 1'b0;
      btn_level = 1'b1;
      sp_seen = 0; lp_seen = 0;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (step_pulse) sp_seen++;
         if (long_press) lp_seen++;
         if (j == 7) chk("en0_held_before", {7'd0, held}, 8'd0);
         if (j == 8) chk("en0_held_after", {7'd0, held}, 8'd1);
      end
      chk("en0_pulses", 8'(sp_seen), 8'd0);
      chk("en0_long", 8'(lp_seen), 8'd0);
      chk("en0_count", step_count, 8'd2);
      btn_level = 1'b0;
      tick();
      en = 1'b1;

      // 256 short presses wrap the counter
      do_reset();
      for (int i = 0; i < 256; i++) begin
         btn_level = 1'b1;
         tick();
         btn_level = 1'b0;
         tick();
         if (i == 254) chk("wrap_255", step_count, 8'd255);
      end
      chk("wrap_0", step_count, 8'd0);

      // async reset in the middle of HELD
      btn_level = 1'b1;
      for (int j = 0; j <= 8; j++) tick();
      chk("midheld_pre_held", {7'd0, held}, 8'd1);
      chk("midheld_pre_lp", {7'd0, long_press}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_sp", {7'd0, step_pulse}, 8'd0);
      chk("async_lp", {7'd0, long_press}, 8'd0);
      chk("async_held", {7'd0, held}, 8'd0);
      chk("async_count", step_count, 8'd0);
      #10;
      rst_n = 1'b1;
      sp_seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (step_pulse) sp_seen++;
      end
      chk("post_reset_no_pulse", 8'(sp_seen), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
